bp_fb_ctrl: RTL and testbench

Branch-feedback controller for the IFU predictor. Collects branch-resolution results from two resolution sources, buffers them in a small in-order queue and retires one update per cycle onto the predictor's single BHT feedback port (`fb_ena` / `fb_taken_stat` / `fb_pc`). An update is issued only in cycles where the predictor is enabled, so no update is ever dropped. Sits between the execute-stage branch units and the predictor.

---
 rtl/bp_fb_ctrl.sv | 129 ++++++++++++
 tb/tb_bp_fb_ctrl.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_fb_ctrl.sv
// Branch-feedback controller: merges two branch-resolution sources into an in-order
// queue and retires one BHT update per enabled cycle. Optional counters: BP_FB_STAT_EN.
module bp_fb_ctrl #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              s0_valid,
    input  logic [ADDR_W-1:0] s0_pc,
    input  logic              s0_taken,
    input  logic              s0_mispred,
    output logic              s0_ready,
    input  logic              s1_valid,
    input  logic [ADDR_W-1:0] s1_pc,
    input  logic              s1_taken,
    input  logic              s1_mispred,
    output logic              s1_ready,
    input  logic              pd_ena,
    output logic              fb_ena,
    output logic              fb_taken_stat,
    output logic [ADDR_W-1:0] fb_pc
`ifdef BP_FB_STAT_EN
    ,
    output logic [31:0]       stat_br_cnt,
    output logic [31:0]       stat_mis_cnt
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0]     head_q, head_d, tail_q, tail_d, s1_slot;
    logic [CW-1:0]     count_q, count_d, free;
    logic              rr_q, rr_d;
    logic [ADDR_W-1:0] pc_q [DEPTH];
    logic [ADDR_W-1:0] pc_d [DEPTH];
    logic [DEPTH-1:0]  taken_q, taken_d;
    logic              s0_acc, s1_acc, pop, contested;
    logic [1:0]        n_push, n_mis;

    always_comb begin
        free      = CW'(DEPTH) - count_q;
        contested = s0_valid && s1_valid && (free == CW'(1));
        // Single free slot with both sources asking: rr picks the winner.
        s0_ready  = !rst && !flush && (free != '0) && !(contested && rr_q);
        s1_ready  = !rst && !flush && (free != '0) && !(contested && !rr_q);
        s0_acc    = s0_valid && s0_ready;
        s1_acc    = s1_valid && s1_ready;
        n_push    = {1'b0, s0_acc} + {1'b0, s1_acc};
        n_mis     = {1'b0, s0_acc && s0_mispred} + {1'b0, s1_acc && s1_mispred};

        fb_ena        = (count_q != '0) && pd_ena && !flush;
        pop           = fb_ena;
        fb_pc         = (count_q != '0) ? pc_q[head_q] : '0;
        fb_taken_stat = (count_q != '0) ? taken_q[head_q] : 1'b0;
    end

    always_comb begin
        pc_d    = pc_q;
        taken_d = taken_q;
        s1_slot = tail_q + PW'(s0_acc);
        if (s0_acc) begin
            pc_d[tail_q]    = s0_pc;
            taken_d[tail_q] = s0_taken;
        end
        if (s1_acc) begin
            pc_d[s1_slot]    = s1_pc;
            taken_d[s1_slot] = s1_taken;
        end

        head_d  = head_q + PW'(pop);
        tail_d  = tail_q + PW'(n_push);
        count_d = count_q + CW'(n_push) - CW'(pop);
        rr_d    = (contested && (s0_acc ^ s1_acc)) ? !rr_q : rr_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            rr_q    <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            rr_q    <= rr_d;
        end
    end

    // Payload needs no reset: fb_* are masked by count when the queue is empty.
    always_ff @(posedge clk) begin
        pc_q    <= pc_d;
        taken_q <= taken_d;
    end

`ifdef BP_FB_STAT_EN
    logic [31:0] stat_br_cnt_q, stat_br_cnt_d, stat_mis_cnt_q, stat_mis_cnt_d;

    always_comb begin
        stat_br_cnt_d  = stat_br_cnt_q + 32'(n_push);
        stat_mis_cnt_d = stat_mis_cnt_q + 32'(n_mis);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_br_cnt_q  <= '0;
            stat_mis_cnt_q <= '0;
        end else begin
            stat_br_cnt_q  <= stat_br_cnt_d;
            stat_mis_cnt_q <= stat_mis_cnt_d;
        end
    end

    assign stat_br_cnt  = stat_br_cnt_q;
    assign stat_mis_cnt = stat_mis_cnt_q;
`else
    logic unused_mis;
    assign unused_mis = ^n_mis;
`endif

endmodule

// File: tb/tb_bp_fb_ctrl.sv
// Scoreboard bench for bp_fb_ctrl: accepted entries are queued as they are driven and
// popped/compared whenever the DUT strobes fb_ena.
module tb_bp_fb_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        s0_valid = 1'b0, s0_taken = 1'b0, s0_mispred = 1'b0, s0_ready;
    logic        s1_valid = 1'b0, s1_taken = 1'b0, s1_mispred = 1'b0, s1_ready;
    logic [31:0] s0_pc = '0, s1_pc = '0;
    logic        pd_ena = 1'b0;
    logic        fb_ena, fb_taken_stat;
    logic [31:0] fb_pc;
`ifdef BP_FB_STAT_EN
    logic [31:0] stat_br_cnt, stat_mis_cnt;
`endif

    bp_fb_ctrl #(.DEPTH(4), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .s0_valid(s0_valid), .s0_pc(s0_pc), .s0_taken(s0_taken), .s0_mispred(s0_mispred), .s0_ready(s0_ready),
        .s1_valid(s1_valid), .s1_pc(s1_pc), .s1_taken(s1_taken), .s1_mispred(s1_mispred), .s1_ready(s1_ready),
        .pd_ena(pd_ena), .fb_ena(fb_ena), .fb_taken_stat(fb_taken_stat), .fb_pc(fb_pc)
`ifdef BP_FB_STAT_EN
        , .stat_br_cnt(stat_br_cnt), .stat_mis_cnt(stat_mis_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        taken;
    } ent_t;

    ent_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_br = 0;
    int   exp_mis = 0;

    // Every retired update must match the oldest accepted entry.
    always @(negedge clk) begin
        if (!rst && fb_ena === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_pop: fb_pc=%h with nothing expected", fb_pc);
            end else begin
                ent_t e;
                e = sb.pop_front();
                if (fb_pc !== e.pc || fb_taken_stat !== e.taken) begin
                    errors++;
                    $display("FAIL sb_order: got pc=%h tk=%b expected pc=%h tk=%b", fb_pc, fb_taken_stat, e.pc, e.taken);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_exp(input logic [31:0] pc, input logic tk, input logic mis);
        ent_t e;
        e.pc = pc;
        e.taken = tk;
        sb.push_back(e);
        exp_br++;
        if (mis) exp_mis++;
    endtask

    task automatic drive0(input logic v, input logic [31:0] pc, input logic tk, input logic mis);
        s0_valid = v; s0_pc = pc; s0_taken = tk; s0_mispred = mis;
    endtask

    task automatic drive1(input logic v, input logic [31:0] pc, input logic tk, input logic mis);
        s1_valid = v; s1_pc = pc; s1_taken = tk; s1_mispred = mis;
    endtask

    task automatic drain(input int bound);
        int n;
        @(posedge clk); #1;
        drive0(0, 0, 0, 0); drive1(0, 0, 0, 0); flush = 0; pd_ena = 1;
        n = 0;
        while (sb.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d entries left, expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
        checks++;
        if (fb_ena !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty_fb_ena: got %b expected 0", fb_ena);
        end
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (fb_ena !== 1'b0 || fb_pc !== 32'h0 || s0_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_held: fb_ena=%b fb_pc=%h s0_ready=%b expected 0 0 0", fb_ena, fb_pc, s0_ready);
        end
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        checks++;
        if (s0_ready !== 1'b1 || s1_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b%b expected 11", s0_ready, s1_ready);
        end
        checks++;
        if (fb_ena !== 1'b0 || fb_pc !== 32'h0 || fb_taken_stat !== 1'b0) begin
            errors++;
            $display("FAIL reset_fb: ena=%b pc=%h tk=%b expected 0 0 0", fb_ena, fb_pc, fb_taken_stat);
        end
`ifdef BP_FB_STAT_EN
        checks++;
        if (stat_br_cnt !== 32'd0 || stat_mis_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_stats: br=%0d mis=%0d expected 0 0", stat_br_cnt, stat_mis_cnt);
        end
`endif
    endtask

    task automatic test_single();
        @(posedge clk); #1;
        pd_ena = 1; drive0(1, 32'h100, 1, 0);
        @(negedge clk);
        checks++;
        if (s0_ready !== 1'b1 || fb_ena !== 1'b0) begin
            errors++;
            $display("FAIL single_accept: ready=%b fb_ena=%b expected 1 0", s0_ready, fb_ena);
        end
        push_exp(32'h100, 1, 0);
        @(posedge clk); #1;
        drive0(0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (fb_ena !== 1'b1 || fb_pc !== 32'h100 || fb_taken_stat !== 1'b1) begin
            errors++;
            $display("FAIL single_retire: ena=%b pc=%h tk=%b expected 1 00000100 1", fb_ena, fb_pc, fb_taken_stat);
        end
        @(negedge clk);
        checks++;
        if (fb_ena !== 1'b0) begin
            errors++;
            $display("FAIL single_after: fb_ena=%b expected 0", fb_ena);
        end
    endtask

    task automatic test_full();
        logic [31:0] want [5];
        want[0] = 32'h10; want[1] = 32'h20; want[2] = 32'h30; want[3] = 32'h40; want[4] = 32'h50;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            pd_ena = 0; drive0(1, want[k], k[0], 0);
            @(negedge clk);
            checks++;
            if (s0_ready !== 1'b1) begin
                errors++;
                $display("FAIL full_fill_%0d: s0_ready=%b expected 1", k, s0_ready);
            end
            push_exp(want[k], k[0], 0);
        end
        @(posedge clk); #1;
        drive0(1, 32'h50, 1, 0);
        @(negedge clk);
        checks++;
        if (s0_ready !== 1'b0 || s1_ready !== 1'b0 || fb_ena !== 1'b0) begin
            errors++;
            $display("FAIL full_refuse: ready=%b%b fb_ena=%b expected 00 0", s0_ready, s1_ready, fb_ena);
        end
        // Full with a pop: still refused this cycle, slot usable next cycle.
        @(posedge clk); #1;
        pd_ena = 1;
        @(negedge clk);
        checks++;
        if (s0_ready !== 1'b0 || fb_ena !== 1'b1 || fb_pc !== want[0]) begin
            errors++;
            $display("FAIL full_pop_refuse: ready=%b ena=%b pc=%h expected 0 1 %h", s0_ready, fb_ena, fb_pc, want[0]);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (s0_ready !== 1'b1 || fb_pc !== want[1]) begin
            errors++;
            $display("FAIL full_slot_reuse: ready=%b pc=%h expected 1 %h", s0_ready, fb_pc, want[1]);
        end
        push_exp(32'h50, 1, 0);
        @(posedge clk); #1;
        drive0(0, 0, 0, 0);
        for (int k = 2; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (fb_ena !== 1'b1 || fb_pc !== want[k]) begin
                errors++;
                $display("FAIL full_drain_%0d: ena=%b pc=%h expected 1 %h", k, fb_ena, fb_pc, want[k]);
            end
        end
        drain(4);
    endtask

    task automatic test_rr();
        @(posedge clk); #1;
        pd_ena = 0; drive0(1, 32'h200, 0, 0); drive1(1, 32'h210, 1, 0);
        @(negedge clk);
        checks++;
        if (s0_ready !== 1'b1 || s1_ready !== 1'b1) begin
            errors++;
            $display("FAIL rr_fill_dual: ready=%b%b expected 11", s0_ready, s1_ready);
        end
        push_exp(32'h200, 0, 0); push_exp(32'h210, 1, 0);
        @(posedge clk); #1;
        drive0(1, 32'h220, 0, 0); drive1(0, 0, 0, 0);
        @(negedge clk);
        push_exp(32'h220, 0, 0);
        @(posedge clk); #1;
        drive0(1, 32'h300, 1, 0); drive1(1, 32'h310, 0, 0);
        @(negedge clk);
        checks++;
        if (s0_ready !== 1'b1 || s1_ready !== 1'b0) begin
            errors++;
            $display("FAIL rr_grant_s0: ready=%b%b expected 10", s0_ready, s1_ready);
        end
        push_exp(32'h300, 1, 0);
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (s0_ready !== 1'b0 || s1_ready !== 1'b0) begin
            errors++;
            $display("FAIL rr_full: ready=%b%b expected 00", s0_ready, s1_ready);
        end
        @(posedge clk); #1;
        drive0(0, 0, 0, 0); drive1(0, 0, 0, 0); pd_ena = 1;
        @(negedge clk);
        @(posedge clk); #1;
        pd_ena = 0; drive0(1, 32'h320, 0, 0); drive1(1, 32'h330, 1, 0);
        @(negedge clk);
        checks++;
        if (s0_ready !== 1'b0 || s1_ready !== 1'b1) begin
            errors++;
            $display("FAIL rr_grant_s1: ready=%b%b expected 01", s0_ready, s1_ready);
        end
        push_exp(32'h330, 1, 0);
        drain(10);
    endtask

    task automatic test_dual();
        @(posedge clk); #1;
        pd_ena = 1; drive0(1, 32'hA0, 0, 0); drive1(1, 32'hB0, 1, 0);
        @(negedge clk);
        checks++;
        if (s0_ready !== 1'b1 || s1_ready !== 1'b1 || fb_ena !== 1'b0) begin
            errors++;
            $display("FAIL dual_accept: ready=%b%b ena=%b expected 11 0", s0_ready, s1_ready, fb_ena);
        end
        push_exp(32'hA0, 0, 0); push_exp(32'hB0, 1, 0);
        @(posedge clk); #1;
        drive0(0, 0, 0, 0); drive1(0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (fb_pc !== 32'hA0 || fb_taken_stat !== 1'b0) begin
            errors++;
            $display("FAIL dual_first: pc=%h tk=%b expected 000000a0 0", fb_pc, fb_taken_stat);
        end
        @(negedge clk);
        checks++;
        if (fb_pc !== 32'hB0 || fb_taken_stat !== 1'b1) begin
            errors++;
            $display("FAIL dual_second: pc=%h tk=%b expected 000000b0 1", fb_pc, fb_taken_stat);
        end
        drain(4);
    endtask

    task automatic test_flush();
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            pd_ena = 0; drive0(1, 32'h500 + 32'(k), 1, 0);
            @(negedge clk);
            push_exp(32'h500 + 32'(k), 1, 0);
        end
        @(posedge clk); #1;
        flush = 1; pd_ena = 1; drive0(1, 32'h5F0, 0, 0); drive1(1, 32'h5F4, 0, 0);
        @(negedge clk);
        checks++;
        if (s0_ready !== 1'b0 || s1_ready !== 1'b0 || fb_ena !== 1'b0) begin
            errors++;
            $display("FAIL flush_cycle: ready=%b%b ena=%b expected 00 0", s0_ready, s1_ready, fb_ena);
        end
        sb.delete();
        @(posedge clk); #1;
        flush = 0; drive0(0, 0, 0, 0); drive1(0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (fb_ena !== 1'b0 || fb_pc !== 32'h0 || s0_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_after: ena=%b pc=%h ready=%b expected 0 0 1", fb_ena, fb_pc, s0_ready);
        end
        @(posedge clk); #1;
        drive1(1, 32'h600, 1, 0);
        @(negedge clk);
        push_exp(32'h600, 1, 0);
        @(posedge clk); #1;
        drive1(0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (fb_ena !== 1'b1 || fb_pc !== 32'h600) begin
            errors++;
            $display("FAIL flush_restart: ena=%b pc=%h expected 1 00000600", fb_ena, fb_pc);
        end
        drain(4);
    endtask

`ifdef BP_FB_STAT_EN
    task automatic test_stats();
        @(posedge clk); #1;
        pd_ena = 1; drive0(1, 32'h700, 1, 1); drive1(1, 32'h704, 0, 0);
        @(negedge clk);
        push_exp(32'h700, 1, 1); push_exp(32'h704, 0, 0);
        @(posedge clk); #1;
        drive0(1, 32'h708, 0, 0); drive1(1, 32'h70C, 1, 0);
        @(negedge clk);
        push_exp(32'h708, 0, 0); push_exp(32'h70C, 1, 0);
        @(posedge clk); #1;
        drive0(1, 32'h710, 1, 1); drive1(0, 0, 0, 0);
        @(negedge clk);
        push_exp(32'h710, 1, 1);
        @(posedge clk); #1;
        drive0(0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (stat_br_cnt !== 32'd5 || stat_mis_cnt !== 32'd2) begin
            errors++;
            $display("FAIL stats_count: br=%0d mis=%0d expected 5 2", stat_br_cnt, stat_mis_cnt);
        end
        @(posedge clk); #1;
        flush = 1;
        @(negedge clk);
        sb.delete();
        @(posedge clk); #1;
        flush = 0;
        @(negedge clk);
        checks++;
        if (stat_br_cnt !== 32'd5 || stat_mis_cnt !== 32'd2) begin
            errors++;
            $display("FAIL stats_flush: br=%0d mis=%0d expected 5 2", stat_br_cnt, stat_mis_cnt);
        end
    endtask
`endif

    task automatic test_stream();
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            pd_ena = ($urandom_range(0, 3) != 0);
            drive0($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            drive1($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            @(negedge clk);
            if (s0_valid && s0_ready === 1'b1) push_exp(s0_pc, s0_taken, s0_mispred);
            if (s1_valid && s1_ready === 1'b1) push_exp(s1_pc, s1_taken, s1_mispred);
        end
        drain(10);
`ifdef BP_FB_STAT_EN
        checks++;
        if (stat_br_cnt !== 32'(exp_br) || stat_mis_cnt !== 32'(exp_mis)) begin
            errors++;
            $display("FAIL stream_stats: br=%0d mis=%0d expected %0d %0d", stat_br_cnt, stat_mis_cnt, exp_br, exp_mis);
        end
`endif
    endtask

    initial begin
        test_reset();
`ifdef BP_FB_STAT_EN
        test_stats();
`endif
        test_single();
        test_full();
        test_rr();
        test_dual();
        test_flush();
        test_stream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
